// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: start/stop controller driving a WIDTH-bit JK flip-flop bank
// as a programmable up/down/load/clear counter with a terminal-value stop.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, STOP       control strobes (STOP has priority)
//   MODE              00 up, 01 down, 10 load, 11 clear (latched on START)
//   LOAD_VAL          value for load mode and auto-reload
//   LIMIT             terminal value for up/down (latched on START)
//   J_OUT, K_OUT      J/K drive applied to the bank this cycle
//   Q                 bank state
//   BUSY              high while running
//   TC                one-cycle pulse after the bank reaches the limit
//   DONE              one-cycle pulse in the DONE state
//
// Optional: define JK_AUTO_RELOAD_EN to reload LOAD_VAL at the limit and keep
// running instead of finishing.
module jk_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] J_OUT,
    output logic [WIDTH-1:0] K_OUT,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             TC,
    output logic             DONE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_UP  = 2'd0;
    localparam logic [1:0] M_DN  = 2'd1;
    localparam logic [1:0] M_LD  = 2'd2;
    localparam logic [1:0] M_CLR = 2'd3;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             at_limit;
    logic             run_ok;

    assign at_limit = (Q == limit_q);
    // STOP forces a hold so the bank keeps its value on abort.
    assign run_ok   = (state == S_RUN) && !STOP;
    assign BUSY     = (state == S_RUN);

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        logic [WIDTH-1:0] low;
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low     = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i] = ((Q & low) == low);
            dn_t[i] = ((Q & low) == '0);
        end
    end

    always_comb begin
        J_OUT = '0;
        K_OUT = '0;
        if (run_ok) begin
            unique case (mode_q)
                M_UP, M_DN: begin
                    if (at_limit) begin
`ifdef JK_AUTO_RELOAD_EN
                        J_OUT = LOAD_VAL;
                        K_OUT = ~LOAD_VAL;
`else
                        J_OUT = '0;
                        K_OUT = '0;
`endif
                    end else if (mode_q == M_UP) begin
                        J_OUT = up_t;
                        K_OUT = up_t;
                    end else begin
                        J_OUT = dn_t;
                        K_OUT = dn_t;
                    end
                end
                M_LD: begin
                    J_OUT = LOAD_VAL;
                    K_OUT = ~LOAD_VAL;
                end
                M_CLR: begin
                    J_OUT = '0;
                    K_OUT = '1;
                end
                default: begin
                    J_OUT = '0;
                    K_OUT = '0;
                end
            endcase
        end
    end

    // JK bank: set on J&~Q, keep a 1 unless K.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= '0;
        end else begin
            Q <= (J_OUT & ~Q) | (~K_OUT & Q);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            mode_q  <= M_UP;
            limit_q <= '0;
            TC      <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            TC   <= 1'b0;
            DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START && !STOP) begin
                        state   <= S_RUN;
                        mode_q  <= MODE;
                        limit_q <= LIMIT;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state <= S_IDLE;
                    end else if (mode_q[1]) begin
                        state <= S_DONE;
                        DONE  <= 1'b1;
                    end else if (at_limit) begin
`ifdef JK_AUTO_RELOAD_EN
                        TC    <= 1'b1;
`else
                        TC    <= 1'b1;
                        state <= S_DONE;
                        DONE  <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb_jk_counter_ctrl: scoreboard bench for jk_counter_ctrl with an
// arithmetic reference model, directed scenarios and random stimulus.
module tb_jk_counter_ctrl;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic         STOP;
    logic [1:0]   MODE;
    logic [W-1:0] LOAD_VAL;
    logic [W-1:0] LIMIT;
    logic [W-1:0] J_OUT;
    logic [W-1:0] K_OUT;
    logic [W-1:0] Q;
    logic         BUSY;
    logic         TC;
    logic         DONE;

    jk_counter_ctrl #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .STOP     (STOP),
        .MODE     (MODE),
        .LOAD_VAL (LOAD_VAL),
        .LIMIT    (LIMIT),
        .J_OUT    (J_OUT),
        .K_OUT    (K_OUT),
        .Q        (Q),
        .BUSY     (BUSY),
        .TC       (TC),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int q;
        int j;
        int k;
        int busy;
        int tc;
        int done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // model: 0 idle, 1 run, 2 done
    int mst, mmode, mlim, mq, mtc, mdone;

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", int'(Q), e.q);
            chk("j_out", int'(J_OUT), e.j);
            chk("k_out", int'(K_OUT), e.k);
            chk("busy", int'(BUSY), e.busy);
            chk("tc", int'(TC), e.tc);
            chk("done", int'(DONE), e.done);
        end
    end

    task automatic model_reset();
        mst   = 0;
        mmode = 0;
        mlim  = 0;
        mq    = 0;
        mtc   = 0;
        mdone = 0;
    endtask

    task automatic step(bit st, bit sp, int md, int lv, int lm);
        exp_t e;
        int   ej, ek, nq, ntc, ndone;
        lv = lv & MASK;
        lm = lm & MASK;
        START    = st;
        STOP     = sp;
        MODE     = md[1:0];
        LOAD_VAL = lv[W-1:0];
        LIMIT    = lm[W-1:0];
        ej = 0;
        ek = 0;
        nq = mq;
        if (mst == 1 && !sp) begin
            if (mmode == 2) begin
                ej = lv;
                ek = ~lv & MASK;
                nq = lv;
            end else if (mmode == 3) begin
                ek = MASK;
                nq = 0;
            end else if (mq == mlim) begin
`ifdef JK_AUTO_RELOAD_EN
                ej = lv;
                ek = ~lv & MASK;
                nq = lv;
`endif
            end else if (mmode == 0) begin
                nq = (mq + 1) & MASK;
                ej = mq ^ nq;
                ek = ej;
            end else begin
                nq = (mq - 1) & MASK;
                ej = mq ^ nq;
                ek = ej;
            end
        end
        e = '{mq, ej, ek, (mst == 1) ? 1 : 0, mtc, mdone};
        sb.push_back(e);
        ntc   = 0;
        ndone = 0;
        case (mst)
            0: if (st && !sp) begin
                mst   = 1;
                mmode = md;
                mlim  = lm;
            end
            1: if (sp) begin
                mst = 0;
            end else if (mmode >= 2) begin
                mst   = 2;
                ndone = 1;
            end else if (mq == mlim) begin
                ntc = 1;
`ifndef JK_AUTO_RELOAD_EN
                mst   = 2;
                ndone = 1;
`endif
            end
            default: mst = 0;
        endcase
        mq    = nq;
        mtc   = ntc;
        mdone = ndone;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n, int lv);
        for (int i = 0; i < n; i++) step(0, 0, 0, lv, 0);
    endtask

    // Asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_q", int'(Q), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_tc", int'(TC), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_j", int'(J_OUT), 0);
        chk("rst_k", int'(K_OUT), 0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int guard;
        START    = 1'b0;
        STOP     = 1'b0;
        MODE     = 2'b00;
        LOAD_VAL = '0;
        LIMIT    = '0;
        RST_N    = 1'b0;
        model_reset();
        #2;
        chk("init_q", int'(Q), 0);
        chk("init_busy", int'(BUSY), 0);
        chk("init_done", int'(DONE), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // up 0..9
        step(1, 0, 0, 0, 9);
        idle(13, 0);

        // clear, then up and reset at Q=5
        step(1, 0, 3, 0, 5);
        idle(3, 0);
        step(1, 0, 0, 0, 15);
        idle(5, 0);
        chk("pre_reset_q", int'(Q), 5);
        do_reset();

        // load 2, then down through wrap to 14
        step(1, 0, 2, 2, 7);
        idle(3, 0);
        step(1, 0, 1, 0, 14);
        idle(8, 0);

        // load 1010, then clear
        step(1, 0, 2, 10, 3);
        idle(3, 10);
        step(1, 0, 3, 10, 3);
        idle(3, 0);

        // stop at 6
        step(1, 0, 0, 0, 15);
        guard = 0;
        while (mq != 6 && guard < 20) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        chk("reach6_budget", guard, 6);
        step(0, 1, 0, 0, 0);
        idle(3, 0);

        // START with STOP in idle
        step(1, 1, 0, 0, 15);
        idle(2, 0);

        // load 3, up to limit 5 (reloads when the option is built)
        step(1, 0, 2, 3, 0);
        idle(3, 3);
        step(1, 0, 0, 3, 5);
        idle(12, 3);
        step(0, 1, 0, 3, 0);
        idle(3, 3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, MASK)));
        end
        idle(4, 0);

        @(negedge CLK);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
